// File: rtl/sky130_sram_1kb_1rw1r_32x256.sv
// 256 x 32-bit synchronous SRAM: port 0 read/write with byte mask, port 1 read-only.
// Both read ports are registered; reads return the pre-write word on a same-cycle collision.
module sky130_sram_1kb_1rw1r_32x256 #(
   parameter int DELAY   = 0,
   parameter int VERBOSE = 0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        csb0,
   input  logic        web0,
   input  logic [3:0]  wmask0,
   input  logic [7:0]  addr0,
   input  logic [31:0] din0,
   output logic [31:0] dout0,
   input  logic        csb1,
   input  logic [7:0]  addr1,
   output logic [31:0] dout1
);

   localparam int unsigned WORDS = 256;
   localparam int unsigned LANES = 4;

   // The delay and trace knobs only shape simulation models; reject values that make no sense.
   if (DELAY < 0) begin : g_bad_delay
      $error("DELAY must be non-negative");
   end
   if (VERBOSE < 0 || VERBOSE > 1) begin : g_bad_verbose
      $error("VERBOSE must be 0 or 1");
   end

   logic [31:0] mem_q [WORDS];
   logic [31:0] dout0_q, dout0_d;
   logic [31:0] dout1_q, dout1_d;
   logic        wr_en, rd0_en, rd1_en;

   always_comb begin
      wr_en   = !csb0 && !web0;
      rd0_en  = !csb0 && web0;
      rd1_en  = !csb1;
      dout0_d = dout0_q;
      dout1_d = dout1_q;
      if (rd0_en) dout0_d = mem_q[addr0];
      if (rd1_en) dout1_d = mem_q[addr1];
   end

   // NOTE: the array has no reset; clearing 256 words is not required and would block RAM inference.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (wmask0[i]) mem_q[addr0][8*i +: 8] <= din0[8*i +: 8];
         end
      end
   end

   // NOTE: non-blocking updates make a same-edge read see the old word, giving read-before-write.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dout0_q <= '0;
         dout1_q <= '0;
      end else begin
         dout0_q <= dout0_d;
         dout1_q <= dout1_d;
      end
   end

   assign dout0 = dout0_q;
   assign dout1 = dout1_q;

endmodule

// File: tb/tb_sky130_sram_1kb_1rw1r_32x256.sv
// Self-checking bench: an array model of the SRAM is compared against both read ports every cycle,
// and directed scenarios pin the model with hand-computed literals.
module tb_sky130_sram_1kb_1rw1r_32x256;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        csb0 = 1'b1;
   logic        web0 = 1'b1;
   logic [3:0]  wmask0 = '0;
   logic [7:0]  addr0 = '0;
   logic [31:0] din0 = '0;
   logic [31:0] dout0;
   logic        csb1 = 1'b1;
   logic [7:0]  addr1 = '0;
   logic [31:0] dout1;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   sky130_sram_1kb_1rw1r_32x256 dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .csb0    (csb0),
      .web0    (web0),
      .wmask0  (wmask0),
      .addr0   (addr0),
      .din0    (din0),
      .dout0   (dout0),
      .csb1    (csb1),
      .addr1   (addr1),
      .dout1   (dout1)
   );

   always #5 i_clk = ~i_clk;

   // Model: an array of words; each edge first serves the reads, then applies the masked write.
   logic [31:0] m_mem [256];
   logic [31:0] exp_dout0, exp_dout1;
   logic [31:0] m_old0, m_old1;

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         exp_dout0 = 32'h0;
         exp_dout1 = 32'h0;
      end else begin
         m_old0 = m_mem[addr0];
         m_old1 = m_mem[addr1];
         if (!csb0 && web0) exp_dout0 = m_old0;
         if (!csb1) exp_dout1 = m_old1;
         if (!csb0 && !web0) begin
            for (int b = 0; b < 4; b++) begin
               if (wmask0[b]) m_mem[addr0][8*b +: 8] = din0[8*b +: 8];
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   always @(negedge i_clk) begin
      if (cmp_en) begin
         check("model_dout0", dout0, exp_dout0);
         check("model_dout1", dout1, exp_dout1);
      end
   end

   // One clock cycle with the given port settings; returns at the following falling edge.
   task automatic cyc(input logic c0, input logic w0, input logic [3:0] m0, input logic [7:0] a0,
                      input logic [31:0] d0, input logic c1, input logic [7:0] a1);
      csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
      @(negedge i_clk);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
      cyc(1'b0, 1'b0, m, a, d, 1'b1, 8'h00);
   endtask

   task automatic rd(input logic [7:0] a0, input logic [7:0] a1);
      cyc(1'b0, 1'b1, 4'h0, a0, 32'h0, 1'b0, a1);
   endtask

   task automatic idle();
      cyc(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00);
   endtask

   initial begin
      repeat (2) @(negedge i_clk);
      check("reset_dout0", dout0, 32'h0);
      check("reset_dout1", dout1, 32'h0);
      i_rst_n = 1'b1;
      cmp_en  = 1'b1;
      idle();

      // Async reset mid-run after a read, and no write while reset is held.
      wr(8'd3, 32'hCAFEF00D, 4'hF);
      rd(8'd3, 8'd3);
      check("pre_reset_dout0", dout0, 32'hCAFEF00D);
      check("pre_reset_dout1", dout1, 32'hCAFEF00D);
      #2 i_rst_n = 1'b0;
      #1;
      check("async_reset_dout0", dout0, 32'h0);
      check("async_reset_dout1", dout1, 32'h0);
      wr(8'd3, 32'h00000000, 4'hF);
      i_rst_n = 1'b1;
      rd(8'd3, 8'd3);
      check("no_write_in_reset", dout0, 32'hCAFEF00D);
      wr(8'd5, 32'hDEADBEEF, 4'hF);
      cyc(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'd5);
      check("p1_read_addr5", dout1, 32'hDEADBEEF);

      // Byte masks, including an all-zero mask.
      wr(8'd7, 32'h11223344, 4'hF);
      wr(8'd7, 32'hAAAAAAAA, 4'b0100);
      rd(8'd7, 8'd7);
      check("mask_lane2", dout0, 32'h11AA3344);
      wr(8'd7, 32'hFFFFFFFF, 4'h0);
      check("dout0_holds_on_write", dout0, 32'h11AA3344);
      rd(8'd7, 8'd5);
      check("mask_zero_noop", dout0, 32'h11AA3344);

      // Byte-lane adapter pattern into word 0.
      for (int k = 0; k < 4; k++) begin
         logic [7:0] bv;
         bv = 8'(k + 1);
         wr(8'd0, {4{bv}}, 4'(1 << k));
      end
      rd(8'd0, 8'd0);
      check("adapter_word0", dout0, 32'h04030201);

      // Collision: port 1 sees the old word, then the new one.
      wr(8'd9, 32'h00000000, 4'hF);
      rd(8'd5, 8'd5);
      cyc(1'b0, 1'b0, 4'hF, 8'd9, 32'h12345678, 1'b0, 8'd9);
      check("collision_old", dout1, 32'h00000000);
      cyc(1'b1, 1'b1, 4'h0, 8'd0, 32'h0, 1'b0, 8'd9);
      check("collision_new", dout1, 32'h12345678);

      // Port 0 read-after-write on the next cycle.
      wr(8'd20, 32'h5A5A1234, 4'hF);
      rd(8'd20, 8'd7);
      check("raw_port0", dout0, 32'h5A5A1234);

      // Chip selects.
      cyc(1'b1, 1'b1, 4'h0, 8'd0, 32'h0, 1'b0, 8'd5);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 4'h0, 8'd0, 32'h0, 1'b1, 8'(i * 37));
      check("csb1_hold", dout1, 32'hDEADBEEF);
      cyc(1'b1, 1'b0, 4'hF, 8'd5, 32'h00000000, 1'b1, 8'd0);
      rd(8'd5, 8'd5);
      check("csb0_no_write", dout0, 32'hDEADBEEF);

      // Address boundaries.
      wr(8'd0,   32'h0F0F0F0F, 4'hF);
      wr(8'd255, 32'hF0E1D2C3, 4'hF);
      rd(8'd0, 8'd255);
      check("addr0_p0",   dout0, 32'h0F0F0F0F);
      check("addr255_p1", dout1, 32'hF0E1D2C3);
      rd(8'd255, 8'd0);
      check("addr255_p0", dout0, 32'hF0E1D2C3);
      check("addr0_p1",   dout1, 32'h0F0F0F0F);

      idle();
      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
